inst_mem_banked: RTL and testbench

//  Parametrised, multi-bank, loadable instruction memory for the 8-bit core.

---
 rtl/inst_mem_banked.sv | 152 +++++++++++++++
 tb/tb_inst_mem_banked.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_mem_banked.sv
// -----------------------------------------------------------------------------
// inst_mem_banked
//   Multi-bank, run-time loadable instruction memory for the 8-bit core.
//   NUM_BANKS independent programs of DEPTH words each. Fetches are registered
//   (latency 1) and the output holds while stalled. A sequential load port
//   rewrites one whole bank, word 0 .. DEPTH-1, while fetches are blocked.
//
// Ports
//   clk, reset     rising-edge clock, synchronous active-high reset
//   bank_sel_i     bank for fetch; captured at load start for the load
//   fetch_req_i    fetch request for address_i
//   stall_i        hold data_o / valid_o
//   address_i      fetch address
//   data_o         fetched word (registered)
//   valid_o        data_o holds a word fetched in the previous cycle
//   load_start_i   begin loading bank bank_sel_i from word 0
//   load_valid_i   load_data_i carries a word
//   load_data_i    load word
//   load_ready_o   high while a load is in progress (beat accepted on valid)
//   load_done_o    one-cycle pulse after the last word of the bank is written
//   busy_o         load in progress; fetches are not served
// -----------------------------------------------------------------------------
module inst_mem_banked #(
    parameter int unsigned       DATA_W       = 8,
    parameter int unsigned       ADDR_W       = 8,
    parameter int unsigned       DEPTH        = 256,
    parameter int unsigned       NUM_BANKS    = 2,
    parameter logic [DATA_W-1:0] DEFAULT_WORD = DATA_W'(8'hFF),
    localparam int unsigned      BANK_W       = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [BANK_W-1:0] bank_sel_i,
    input  logic              fetch_req_i,
    input  logic              stall_i,
    input  logic [ADDR_W-1:0] address_i,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o,
    input  logic              load_start_i,
    input  logic              load_valid_i,
    input  logic [DATA_W-1:0] load_data_i,
    output logic              load_ready_o,
    output logic              load_done_o,
    output logic              busy_o
);

    localparam int unsigned       PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    typedef enum logic {
        S_FETCH,
        S_LOAD
    } state_t;

    state_t            state, state_next;
    logic [PTR_W-1:0]  ptr, ptr_next;
    logic [BANK_W-1:0] load_bank, load_bank_next;
    logic              done_next;
    logic              mem_we;
    logic              load_bank_ok;
    logic              fetch_addr_ok;
    logic              fetch_bank_ok;
    logic [DATA_W-1:0] fetch_word;

    logic [DATA_W-1:0] mem [NUM_BANKS][DEPTH];

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_FETCH;
            ptr         <= '0;
            load_bank   <= '0;
            load_done_o <= 1'b0;
        end else begin
            state       <= state_next;
            ptr         <= ptr_next;
            load_bank   <= load_bank_next;
            load_done_o <= done_next;
        end
    end

    always_comb begin
        state_next     = state;
        ptr_next       = ptr;
        load_bank_next = load_bank;
        done_next      = 1'b0;
        mem_we         = 1'b0;
        busy_o         = 1'b0;
        load_ready_o   = 1'b0;
        case (state)
            S_FETCH: begin
                if (load_start_i) begin
                    state_next     = S_LOAD;
                    ptr_next       = '0;
                    load_bank_next = bank_sel_i;
                end
            end
            S_LOAD: begin
                busy_o       = 1'b1;
                load_ready_o = 1'b1;
                if (load_valid_i) begin
                    mem_we = 1'b1;
                    if (ptr == LAST_PTR) begin
                        state_next = S_FETCH;
                        ptr_next   = '0;
                        done_next  = 1'b1;
                    end else begin
                        ptr_next = ptr + 1'b1;
                    end
                end
            end
            default: state_next = S_FETCH;
        endcase
    end

    // ---------------------------------------------------------------- memory
    // A load aimed at a non-existent bank still runs its beats but writes nothing.
    assign load_bank_ok = 32'(load_bank) < NUM_BANKS;

    always_ff @(posedge clk) begin
        if (!reset && mem_we && load_bank_ok) begin
            mem[load_bank][ptr] <= load_data_i;
        end
    end

    // ---------------------------------------------------------------- fetch
    assign fetch_addr_ok = 32'(address_i) < DEPTH;
    assign fetch_bank_ok = 32'(bank_sel_i) < NUM_BANKS;

    always_comb begin
        fetch_word = DEFAULT_WORD;
        if (fetch_addr_ok && fetch_bank_ok) begin
            fetch_word = mem[bank_sel_i][address_i[PTR_W-1:0]];
        end
    end

    // Stall has priority over everything, including the idle/load clear of valid_o.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_o  <= DEFAULT_WORD;
            valid_o <= 1'b0;
        end else if (!stall_i) begin
            if (state == S_FETCH && fetch_req_i) begin
                data_o  <= fetch_word;
                valid_o <= 1'b1;
            end else begin
                valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_inst_mem_banked.sv
module tb_inst_mem_banked;

    localparam int unsigned DATA_W    = 8;
    localparam int unsigned ADDR_W    = 8;
    localparam int unsigned DEPTH     = 200;
    localparam int unsigned NUM_BANKS = 3;
    localparam int unsigned BANK_W    = 2;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [BANK_W-1:0] bank_sel_i = '0;
    logic              fetch_req_i = 1'b0;
    logic              stall_i = 1'b0;
    logic [ADDR_W-1:0] address_i = '0;
    logic [DATA_W-1:0] data_o;
    logic              valid_o;
    logic              load_start_i = 1'b0;
    logic              load_valid_i = 1'b0;
    logic [DATA_W-1:0] load_data_i = '0;
    logic              load_ready_o;
    logic              load_done_o;
    logic              busy_o;

    always #5 clk = ~clk;

    inst_mem_banked #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .DEPTH(DEPTH),
        .NUM_BANKS(NUM_BANKS),
        .DEFAULT_WORD(8'hFF)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bank_sel_i(bank_sel_i),
        .fetch_req_i(fetch_req_i),
        .stall_i(stall_i),
        .address_i(address_i),
        .data_o(data_o),
        .valid_o(valid_o),
        .load_start_i(load_start_i),
        .load_valid_i(load_valid_i),
        .load_data_i(load_data_i),
        .load_ready_o(load_ready_o),
        .load_done_o(load_done_o),
        .busy_o(busy_o)
    );

    typedef struct {
        logic [7:0] data;
        logic       valid;
        logic       busy;
        logic       done;
    } exp_t;

    exp_t exp_q[$];
    int   passed = 0;
    int   total  = 0;

    // Reference model: program contents plus what the outputs should read.
    logic [7:0]  ref_mem [NUM_BANKS][DEPTH];
    bit          m_loading = 0;
    int unsigned m_bank    = 0;
    int unsigned m_ptr     = 0;
    logic [7:0]  m_data    = 8'hFF;
    bit          m_valid   = 0;
    logic [7:0]  load_buf [DEPTH];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // One clock of stimulus; the expected post-edge outputs go to the scoreboard.
    task automatic step(input bit rst, input int unsigned sel, input bit req, input bit stl,
                        input int unsigned addr, input bit ls, input bit lv, input logic [7:0] ld);
        exp_t e;
        bit   done;
        done = 0;
        @(negedge clk);
        reset        = rst;
        bank_sel_i   = BANK_W'(sel);
        fetch_req_i  = req;
        stall_i      = stl;
        address_i    = ADDR_W'(addr);
        load_start_i = ls;
        load_valid_i = lv;
        load_data_i  = ld;
        if (rst) begin
            m_data = 8'hFF; m_valid = 0; m_loading = 0; m_ptr = 0;
        end else begin
            if (!stl) begin
                if (!m_loading && req) begin
                    m_valid = 1;
                    m_data  = (addr >= DEPTH || sel >= NUM_BANKS) ? 8'hFF : ref_mem[sel][addr];
                end else begin
                    m_valid = 0;
                end
            end
            if (!m_loading) begin
                if (ls) begin m_loading = 1; m_bank = sel; m_ptr = 0; end
            end else if (lv) begin
                if (m_bank < NUM_BANKS) ref_mem[m_bank][m_ptr] = ld;
                if (m_ptr == DEPTH - 1) begin m_loading = 0; done = 1; end
                else m_ptr++;
            end
        end
        e.data  = m_data;
        e.valid = m_valid;
        e.busy  = m_loading;
        e.done  = done;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0, 0, 0, 0, 0, 0, 8'h00);
    endtask

    task automatic fetch(input int unsigned sel, input int unsigned addr);
        step(0, sel, 1, 0, addr, 0, 0, 8'h00);
    endtask

    // Load load_buf[0..nbeats-1] into bank; gaps insert idle beats, fetch_req held high.
    task automatic load(input int unsigned bank, input int nbeats, input bit gaps, input bit req_high);
        step(0, bank, 0, 0, 0, 1, 0, 8'h00);
        for (int i = 0; i < nbeats; i++) begin
            if (gaps) begin
                while ($urandom_range(0, 2) == 0)
                    step(0, bank, req_high, 0, $urandom_range(0, 255), 0, 0, 8'h00);
            end
            step(0, bank, req_high, 0, $urandom_range(0, 255), 0, 1, load_buf[i]);
        end
    endtask

    // Monitor: one scoreboard entry per clock, checked shortly after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("data_o",       data_o,                e.data);
                check("valid_o",      {7'd0, valid_o},       {7'd0, e.valid});
                check("busy_o",       {7'd0, busy_o},        {7'd0, e.busy});
                check("load_ready_o", {7'd0, load_ready_o},  {7'd0, e.busy});
                check("load_done_o",  {7'd0, load_done_o},   {7'd0, e.done});
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        step(1, 0, 0, 0, 0, 0, 0, 8'h00);
        step(1, 0, 0, 0, 0, 0, 0, 8'h00);
        idle(2);

        // Full contiguous load of bank0 with word i = i
        for (int i = 0; i < DEPTH; i++) load_buf[i] = 8'(i);
        load(0, DEPTH, 0, 0);
        idle(3);

        // Simple fetch, then idle
        fetch(0, 43);
        idle(1);

        // Fetch then stall three cycles with a different address, then release
        fetch(0, 10);
        repeat (3) step(0, 0, 1, 1, 20, 0, 0, 8'h00);
        fetch(0, 20);
        idle(1);

        // Bank1 = ~i with gaps and fetch requests held high during the load
        for (int i = 0; i < DEPTH; i++) load_buf[i] = ~8'(i);
        load(1, DEPTH, 1, 1);
        fetch(1, 5);
        fetch(0, 5);

        // Bank2 random contents
        for (int i = 0; i < DEPTH; i++) load_buf[i] = 8'($urandom);
        load(2, DEPTH, 1, 0);

        // Out-of-range address and bank
        fetch(0, 250);
        fetch(3, 7);
        fetch(1, DEPTH - 1);
        fetch(2, DEPTH);
        idle(1);

        // Random fetch / stall traffic
        repeat (300)
            step(0, $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3) == 0,
                 $urandom_range(0, 255), 0, 0, 8'h00);

        // Reset after 100 beats of a bank0 load
        for (int i = 0; i < DEPTH; i++) load_buf[i] = 8'(8'h40 + i);
        load(0, 100, 0, 0);
        step(1, 0, 0, 0, 0, 0, 1, 8'hEE);
        fetch(1, 7);
        fetch(0, 99);
        fetch(0, 100);
        fetch(0, 0);
        idle(1);
        for (int i = 0; i < DEPTH; i++) load_buf[i] = 8'(8'h80 ^ i);
        load(0, DEPTH, 1, 0);
        fetch(0, 0);
        fetch(0, 1);
        fetch(0, 150);
        fetch(0, DEPTH - 1);

        // Mixed random traffic including loads started alongside fetches
        repeat (1500) begin
            int unsigned sel;
            sel = $urandom_range(0, 3);
            step(0, sel, $urandom_range(0, 1), $urandom_range(0, 4) == 0, $urandom_range(0, 255),
                 (sel < NUM_BANKS) && ($urandom_range(0, 29) == 0),
                 $urandom_range(0, 9) < 6, 8'($urandom));
        end
        // Drain any load still in progress, then read back random words
        while (m_loading) step(0, 0, 0, 0, 0, 0, 1, 8'($urandom));
        repeat (60) fetch($urandom_range(0, 2), $urandom_range(0, DEPTH - 1));
        idle(2);

        @(posedge clk);
        #3;
        total++;
        if (exp_q.size() == 0) passed++;
        else $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
